iter_shifter: RTL and testbench

Parametrised, multi-cycle shift/rotate engine. It is the sequential successor of the lab 4-bit combinational shifter and keeps the same `dir` convention: 1 = right, 0 = left. It adds arithmetic and rotate modes, generic width, and a configurable shift step per cycle. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register-file stage and a writeback stage.

---
 rtl/iter_shifter.sv | 136 +++++++++++++
 tb/tb_iter_shifter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module : iter_shifter
// Multi-cycle shift/rotate engine with valid/ready operand and result ports.
// Rev    : 1.0  initial release
// ============================================================================
module iter_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_ARITH = 2'b01;
    localparam logic [1:0] M_ROT   = 2'b10;

    localparam logic [AMT_W-1:0] C_STEP_A = AMT_W'(STEP);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;

    logic [31:0]      w_rem_ext;
    logic [AMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] w_stepped;

    // Single-bit move; arithmetic right replicates the MSB, which the working
    // register keeps equal to the captured operand's sign throughout.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                                input logic             right,
                                                input logic [1:0]       m);
        logic [WIDTH-1:0] res;
        if (right) begin
            res = {(m == M_ROT) ? v[0] : ((m == M_ARITH) ? v[WIDTH-1] : 1'b0),
                   v[WIDTH-1:1]};
        end else begin
            res = {v[WIDTH-2:0], (m == M_ROT) ? v[WIDTH-1] : 1'b0};
        end
        return res;
    endfunction

    // Up to STEP single-bit moves per cycle, bounded by the remaining count.
    always_comb begin
        w_rem_ext = {{(32-AMT_W){1'b0}}, rem_q};
        w_stepped = work_q;
        for (int i = 0; i < STEP; i++) begin
            if (32'(i) < w_rem_ext) begin
                w_stepped = shift1(w_stepped, dir_q, mode_q);
            end
        end
        if (w_rem_ext >= 32'(STEP)) begin
            w_rem_next = rem_q - C_STEP_A;
        end else begin
            w_rem_next = '0;
        end
    end

    // A zero amount still spends one cycle in SHIFT so results never appear
    // on the accept edge itself.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = a;
                    rem_d   = amt;
                    dir_d   = dir;
                    mode_d  = mode;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = w_stepped;
                rem_d  = w_rem_next;
                if (w_rem_next == '0) begin
                    d_d     = w_stepped;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign d         = d_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module : tb_iter_shifter
// Self-checking bench for iter_shifter (8-bit step 1 / step 4, 4-bit lab mode).
// Rev    : 1.0  initial release
// ============================================================================
module tb_iter_shifter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       s1_in_valid, s1_in_ready, s1_dir, s1_out_valid, s1_out_ready, s1_busy;
    logic [7:0] s1_a, s1_d;
    logic [3:0] s1_amt;
    logic [1:0] s1_mode;

    logic       s4_in_valid, s4_in_ready, s4_dir, s4_out_valid, s4_out_ready, s4_busy;
    logic [7:0] s4_a, s4_d;
    logic [3:0] s4_amt;
    logic [1:0] s4_mode;

    logic       w4_in_valid, w4_in_ready, w4_dir, w4_out_valid, w4_out_ready, w4_busy;
    logic [3:0] w4_a, w4_d;
    logic [1:0] w4_amt;
    logic [1:0] w4_mode;

    iter_shifter #(.WIDTH(8), .AMT_W(4), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .a(s1_a), .amt(s1_amt), .dir(s1_dir), .mode(s1_mode),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .d(s1_d), .busy(s1_busy));

    iter_shifter #(.WIDTH(8), .AMT_W(4), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
        .a(s4_a), .amt(s4_amt), .dir(s4_dir), .mode(s4_mode),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .d(s4_d), .busy(s4_busy));

    iter_shifter #(.WIDTH(4), .AMT_W(2), .STEP(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .amt(w4_amt), .dir(w4_dir), .mode(w4_mode),
        .out_valid(w4_out_valid), .out_ready(w4_out_ready), .d(w4_d), .busy(w4_busy));

    // Reference: whole-amount shift/rotate of an 8-bit operand.
    function automatic logic [7:0] ref8(input logic [7:0] x, input int n,
                                        input logic r, input logic [1:0] m);
        logic [15:0]       dbl;
        logic signed [7:0] sx;
        sx = x;
        if (m == 2'b10) begin
            dbl = {x, x};
            if (r) begin
                dbl = dbl >> (n % 8);
                return dbl[7:0];
            end
            dbl = dbl << (n % 8);
            return dbl[15:8];
        end
        if (r && m == 2'b01) return (n >= 8) ? {8{x[7]}} : 8'(sx >>> n);
        if (n >= 8) return 8'h00;
        return r ? 8'(x >> n) : 8'(x << n);
    endfunction

    // Reference: original 4-bit combinational lab shifter (logical only).
    function automatic logic [3:0] ref4(input logic [3:0] x, input int n, input logic r);
        return r ? 4'(x >> n) : 4'(x << n);
    endfunction

    function automatic int exp_lat(input int n, input int step);
        return (n == 0) ? 1 : (n + step - 1) / step;
    endfunction

    // Drivers: present one operand, return edges from accept to out_valid (-1 on timeout).
    task automatic s1_op(input logic [7:0] x, input logic [3:0] n, input logic r,
                         input logic [1:0] m, output int lat, output logic [7:0] res);
        int guard;
        guard = 0;
        @(negedge clk);
        s1_a = x; s1_amt = n; s1_dir = r; s1_mode = m; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
        while (!s1_in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (s1_out_valid) begin lat = c; break; end
        end
        res = s1_d;
    endtask

    task automatic s4_op(input logic [7:0] x, input logic [3:0] n, input logic r,
                         input logic [1:0] m, output int lat, output logic [7:0] res);
        int guard;
        guard = 0;
        @(negedge clk);
        s4_a = x; s4_amt = n; s4_dir = r; s4_mode = m; s4_in_valid = 1'b1; s4_out_ready = 1'b1;
        while (!s4_in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        s4_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (s4_out_valid) begin lat = c; break; end
        end
        res = s4_d;
    endtask

    task automatic w4_op(input logic [3:0] x, input logic [1:0] n, input logic r,
                         output int lat, output logic [3:0] res);
        int guard;
        guard = 0;
        @(negedge clk);
        w4_a = x; w4_amt = n; w4_dir = r; w4_mode = 2'b00; w4_in_valid = 1'b1; w4_out_ready = 1'b1;
        while (!w4_in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        w4_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (w4_out_valid) begin lat = c; break; end
        end
        res = w4_d;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (s1_d !== 8'h00) begin bad++; $display("FAIL reset_d: got %h want 00", s1_d); end
        total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", s1_out_valid); end
        total++; if (s1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", s1_busy); end
        total++; if (s1_in_ready !== 1'b0) begin bad++; $display("FAIL reset_irdy_low: got %b want 0", s1_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL reset_irdy_high: got %b want 1", s1_in_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'hB6, 8'hB6, 8'h81, 8'hFF, 8'h80, 8'h80};
        logic [3:0] tn [6] = '{4'd3, 4'd3, 4'd9, 4'd12, 4'd15, 4'd15};
        logic       td [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] tm [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
        logic [7:0] te [6] = '{8'h16, 8'hF6, 8'h03, 8'h00, 8'hFF, 8'h00};
        int         tl [6] = '{3, 3, 9, 12, 15, 15};
        int         lat;
        logic [7:0] res;
        for (int i = 0; i < 6; i++) begin
            s1_op(ta[i], tn[i], td[i], tm[i], lat, res);
            total++; if (res !== te[i]) begin bad++; $display("FAIL dir_d[%0d]: got %h want %h", i, res, te[i]); end
            total++; if (lat !== tl[i]) begin bad++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, tl[i]); end
            @(posedge clk); #1;
            total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL dir_ov_pulse[%0d]: got %b want 0", i, s1_out_valid); end
        end
        s4_op(8'h81, 4'd9, 1'b0, 2'b10, lat, res);
        total++; if (res !== 8'h03) begin bad++; $display("FAIL step4_rot_d: got %h want 03", res); end
        total++; if (lat !== 3) begin bad++; $display("FAIL step4_rot_lat: got %0d want 3", lat); end
    endtask

    task automatic test_random();
        logic [7:0] x, res;
        logic [3:0] n;
        logic       r;
        logic [1:0] m;
        int         lat;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom); n = 4'($urandom); r = 1'($urandom); m = 2'($urandom);
            if (i < 25) begin
                s1_op(x, n, r, m, lat, res);
                total++; if (res !== ref8(x, int'(n), r, m)) begin bad++; $display("FAIL rnd1_d: a=%h amt=%0d dir=%b mode=%b got %h want %h", x, n, r, m, res, ref8(x, int'(n), r, m)); end
                total++; if (lat !== exp_lat(int'(n), 1)) begin bad++; $display("FAIL rnd1_lat: amt=%0d got %0d want %0d", n, lat, exp_lat(int'(n), 1)); end
            end else begin
                s4_op(x, n, r, m, lat, res);
                total++; if (res !== ref8(x, int'(n), r, m)) begin bad++; $display("FAIL rnd4_d: a=%h amt=%0d dir=%b mode=%b got %h want %h", x, n, r, m, res, ref8(x, int'(n), r, m)); end
                total++; if (lat !== exp_lat(int'(n), 4)) begin bad++; $display("FAIL rnd4_lat: amt=%0d got %0d want %0d", n, lat, exp_lat(int'(n), 4)); end
            end
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        @(negedge clk);
        total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_rdy: got %b want 1", s1_in_ready); end
        s1_a = 8'h5A; s1_amt = 4'd0; s1_dir = 1'b0; s1_mode = 2'b00; s1_in_valid = 1'b1; s1_out_ready = 1'b0;
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (s1_out_valid !== 1'b1) begin bad++; $display("FAIL bp_zero_ov: got %b want 1", s1_out_valid); end
        total++; if (s1_d !== 8'h5A) begin bad++; $display("FAIL bp_zero_d: got %h want 5a", s1_d); end
        @(negedge clk);
        s1_a = 8'hC3; s1_amt = 4'd2; s1_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (s1_d !== 8'h5A) begin bad++; $display("FAIL bp_hold_d[%0d]: got %h want 5a", c, s1_d); end
            total++; if (s1_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_ov[%0d]: got %b want 1", c, s1_out_valid); end
            total++; if (s1_in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_rdy[%0d]: got %b want 0", c, s1_in_ready); end
        end
        @(negedge clk);
        s1_out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_ov: got %b want 0", s1_out_valid); end
        total++; if (s1_busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy: got %b want 0", s1_busy); end
        total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_rdy: got %b want 1", s1_in_ready); end
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        total++; if (s1_busy !== 1'b1) begin bad++; $display("FAIL bp_accept_busy: got %b want 1", s1_busy); end
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (s1_out_valid) begin lat = c; break; end
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL bp_c3_lat: got %0d want 2", lat); end
        total++; if (s1_d !== 8'h0C) begin bad++; $display("FAIL bp_c3_d: got %h want 0c", s1_d); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int         lat;
        logic [7:0] res;
        @(negedge clk);
        s1_a = 8'hA5; s1_amt = 4'd10; s1_dir = 1'b1; s1_mode = 2'b00; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (s1_d !== 8'h00) begin bad++; $display("FAIL mid_rst_d: got %h want 00", s1_d); end
        total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_ov: got %b want 0", s1_out_valid); end
        total++; if (s1_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", s1_busy); end
        total++; if (s1_in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_rdy: got %b want 0", s1_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL mid_post_rdy: got %b want 1", s1_in_ready); end
        s1_op(8'h81, 4'd1, 1'b1, 2'b00, lat, res);
        total++; if (res !== 8'h40) begin bad++; $display("FAIL mid_post_d: got %h want 40", res); end
        total++; if (lat !== 1) begin bad++; $display("FAIL mid_post_lat: got %0d want 1", lat); end
    endtask

    task automatic test_exhaustive_lab();
        int         lat;
        logic [3:0] res;
        for (int x = 0; x < 16; x++) begin
            for (int n = 0; n < 4; n++) begin
                for (int r = 0; r < 2; r++) begin
                    w4_op(4'(x), 2'(n), 1'(r), lat, res);
                    total++; if (res !== ref4(4'(x), n, 1'(r))) begin bad++; $display("FAIL lab4_d: a=%h amt=%0d dir=%0d got %h want %h", x, n, r, res, ref4(4'(x), n, 1'(r))); end
                    total++; if (lat !== exp_lat(n, 1)) begin bad++; $display("FAIL lab4_lat: amt=%0d got %0d want %0d", n, lat, exp_lat(n, 1)); end
                end
            end
        end
    endtask

    initial begin
        s1_in_valid = 1'b0; s1_a = '0; s1_amt = '0; s1_dir = 1'b0; s1_mode = '0; s1_out_ready = 1'b0;
        s4_in_valid = 1'b0; s4_a = '0; s4_amt = '0; s4_dir = 1'b0; s4_mode = '0; s4_out_ready = 1'b0;
        w4_in_valid = 1'b0; w4_a = '0; w4_amt = '0; w4_dir = 1'b0; w4_mode = '0; w4_out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_midop();
        test_exhaustive_lab();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
